// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M execute-stage multiply/divide unit.
// Multiplies take 2 cycles. Divides use a radix-2 restoring divider that
// resolves one quotient bit per edge, starting on the accept edge, so a
// normal divide completes XLEN edges after accept. Divide-by-zero, signed
// overflow and non-M codes finish on the accept edge itself.

package riscv_defines;
   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_AND    = 5'd2,
      ALU_OR     = 5'd3,
      ALU_XOR    = 5'd4,
      ALU_SLT    = 5'd5,
      ALU_SLL    = 5'd6,
      ALU_SRL    = 5'd7,
      ALU_MUL    = 5'd8,
      ALU_MULH   = 5'd9,
      ALU_MULHSU = 5'd10,
      ALU_MULHU  = 5'd11,
      ALU_DIV    = 5'd12,
      ALU_DIVU   = 5'd13,
      ALU_REM    = 5'd14,
      ALU_REMU   = 5'd15,
      ALU_SRA    = 5'd16,
      ALU_SLTU   = 5'd17
   } alucontrol_t;
endpackage

module muldiv_unit
   import riscv_defines::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      alucontrol,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t            state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   alucontrol_t       op_q, op_d;
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [XLEN-1:0]   quo_q, quo_d;

   // One restoring step: shift the next dividend bit into the partial
   // remainder, subtract the divisor if it fits, shift the quotient bit in.
   function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                  input logic [XLEN-1:0] quo,
                                                  input logic [XLEN-1:0] dvs);
      logic [XLEN:0] shifted;
      logic [XLEN:0] trial;
      shifted = {rem, quo[XLEN-1]};
      trial   = shifted - {1'b0, dvs};
      if (!trial[XLEN]) return {trial[XLEN-1:0], quo[XLEN-2:0], 1'b1};
      else              return {shifted[XLEN-1:0], quo[XLEN-2:0], 1'b0};
   endfunction

   // Decode of the incoming request: class, operand magnitudes, special cases.
   alucontrol_t     op_in;
   logic            is_mul_in, is_div_in, sgn_in, div0_in, ovf_in;
   logic [XLEN-1:0] a_mag_in, b_mag_in, special_res;
   logic [2*XLEN-1:0] step_in;
   always_comb begin
      op_in     = alucontrol_t'(alucontrol);
      is_mul_in = (op_in == ALU_MUL) || (op_in == ALU_MULH) ||
                  (op_in == ALU_MULHSU) || (op_in == ALU_MULHU);
      is_div_in = (op_in == ALU_DIV) || (op_in == ALU_DIVU) ||
                  (op_in == ALU_REM) || (op_in == ALU_REMU);
      sgn_in    = (op_in == ALU_DIV) || (op_in == ALU_REM);
      a_mag_in  = (sgn_in && src_a[XLEN-1]) ? -src_a : src_a;
      b_mag_in  = (sgn_in && src_b[XLEN-1]) ? -src_b : src_b;
      div0_in   = (src_b == '0);
      ovf_in    = sgn_in && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
      special_res = '0;
      if (is_div_in && div0_in)
         special_res = ((op_in == ALU_DIV) || (op_in == ALU_DIVU)) ? '1 : src_a;
      else if (is_div_in && ovf_in)
         special_res = (op_in == ALU_DIV) ? src_a : '0;
      step_in = div_step('0, a_mag_in, b_mag_in);
   end

   // Multiply datapath on registered operands: sign-extend per opcode, take one product.
   logic              a_sx, b_sx;
   logic [2*XLEN+1:0] a_w, b_w, prod;
   logic [XLEN-1:0]   mul_res;
   always_comb begin
      a_sx    = ((op_q == ALU_MUL) || (op_q == ALU_MULH) || (op_q == ALU_MULHSU)) && a_q[XLEN-1];
      b_sx    = ((op_q == ALU_MUL) || (op_q == ALU_MULH)) && b_q[XLEN-1];
      a_w     = {{(XLEN+2){a_sx}}, a_q};
      b_w     = {{(XLEN+2){b_sx}}, b_q};
      prod    = a_w * b_w;
      mul_res = (op_q == ALU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

   // Divide iteration on registered state, with final sign correction.
   logic              sgn_q, a_neg_q, b_neg_q;
   logic [XLEN-1:0]   dvs_mag, quo_fix, rem_fix, div_res;
   logic [2*XLEN-1:0] step_it;
   always_comb begin
      sgn_q   = (op_q == ALU_DIV) || (op_q == ALU_REM);
      a_neg_q = sgn_q && a_q[XLEN-1];
      b_neg_q = sgn_q && b_q[XLEN-1];
      dvs_mag = b_neg_q ? -b_q : b_q;
      step_it = div_step(rem_q, quo_q, dvs_mag);
      quo_fix = (a_neg_q ^ b_neg_q) ? -step_it[XLEN-1:0] : step_it[XLEN-1:0];
      rem_fix = a_neg_q ? -step_it[2*XLEN-1:XLEN] : step_it[2*XLEN-1:XLEN];
      div_res = ((op_q == ALU_DIV) || (op_q == ALU_DIVU)) ? quo_fix : rem_fix;
   end

   // Next-state logic: FSM transitions, operand capture, result write, flush override.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q && !flush) begin
               a_d   = src_a;
               b_d   = src_b;
               op_d  = op_in;
               cnt_d = '0;
               if (is_mul_in) begin
                  state_d = S_MUL;
               end else if (is_div_in && !div0_in && !ovf_in) begin
                  state_d = S_DIV;
                  rem_d   = step_in[2*XLEN-1:XLEN];
                  quo_d   = step_in[XLEN-1:0];
                  cnt_d   = CW'(1);
               end else begin
                  state_d  = S_DONE;
                  result_d = special_res;
               end
            end
         end
         S_MUL: begin
            state_d  = S_DONE;
            result_d = mul_res;
         end
         S_DIV: begin
            rem_d = step_it[2*XLEN-1:XLEN];
            quo_d = step_it[XLEN-1:0];
            if (cnt_q == CW'(XLEN-1)) begin
               state_d  = S_DONE;
               cnt_d    = '0;
               result_d = div_res;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         result_d = result_q;
      end
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         result_q    <= '0;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= ALU_ADD;
         rem_q       <= '0;
         quo_q       <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         result_q    <= result_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latencies, backpressure, flush, reset.
module tb_muldiv_unit;
   import riscv_defines::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  alucontrol;
   logic [31:0] src_a, src_b;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        busy;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alucontrol (alucontrol),
      .src_a      (src_a),
      .src_b      (src_b),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Issue one op, measure edges from accept to out_valid, check result, retire it.
   task automatic run_op(input string tag, input alucontrol_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int lat;
      chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid   = 1'b1;
      alucontrol = op;
      src_a      = a;
      src_b      = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      src_a    = 32'h0;
      src_b    = 32'h0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, ".res"}, result, exp_res);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ".idle"}, {30'd0, in_ready, out_valid}, 32'd2);
   endtask

   initial begin
      int seen_valid;
      reset      = 1'b1;
      in_valid   = 1'b0;
      alucontrol = 5'd0;
      src_a      = 32'h0;
      src_b      = 32'h0;
      flush      = 1'b0;
      out_ready  = 1'b0;
      #12;
      chk("rst.in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst.busy",      {31'd0, busy},      32'd0);
      chk("rst.result",    result,             32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;

      // multiply
      run_op("mul",    ALU_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
      run_op("mulh",   ALU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2);
      run_op("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
      run_op("mulhu",  ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
      // divide, normal path
      run_op("div",    ALU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32);
      run_op("rem",    ALU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32);
      run_op("divu",   ALU_DIVU,   32'd100,       32'd7,         32'd14,        32);
      run_op("remu",   ALU_REMU,   32'd100,       32'd7,         32'd2,         32);
      run_op("div_pn", ALU_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32);
      run_op("rem_pn", ALU_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         32);
      run_op("divu_m", ALU_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32);
      // special cases
      run_op("divu0",  ALU_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      run_op("rem0",   ALU_REM,    32'd5,         32'd0,         32'd5,         1);
      run_op("divovf", ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("removf", ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
      run_op("nonm",   ALU_ADD,    32'd3,         32'd4,         32'h0000_0000, 1);

      // backpressure in DONE
      in_valid   = 1'b1;
      alucontrol = ALU_MUL;
      src_a      = 32'd6;
      src_b      = 32'd9;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("hold.valid", {31'd0, out_valid}, 32'd1);
         chk("hold.res",   result,             32'd54);
         chk("hold.ready", {31'd0, in_ready},  32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("hold.rel", {29'd0, in_ready, out_valid, busy}, 32'd4);

      // flush on the edge processing iteration 10 of a divide
      in_valid   = 1'b1;
      alucontrol = ALU_DIVU;
      src_a      = 32'd1000;
      src_b      = 32'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
      end
      chk("flush.busy_pre", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush.state", {29'd0, in_ready, out_valid, busy}, 32'd4);
      seen_valid = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen_valid = 1;
      end
      chk("flush.no_valid", 32'(seen_valid), 32'd0);
      chk("flush.res",      result,          32'd54);

      // async reset in the middle of a multiply
      in_valid   = 1'b1;
      alucontrol = ALU_MUL;
      src_a      = 32'd5;
      src_b      = 32'd5;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("arst.busy_pre", {31'd0, busy}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst.state",  {29'd0, in_ready, out_valid, busy}, 32'd4);
      chk("arst.result", result, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("arst.after", {29'd0, in_ready, out_valid, busy}, 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
